// File: rtl/work_controller_if.sv
// Panel-side bundle for work_controller: key pulses in, run-state levels out.
interface work_controller_if;
  logic       key_inc;
  logic       key_confirm;
  logic       key_start;
  logic       key_stop;
  logic       work_mode;
  logic       start;
  logic       finish;
  logic       stop;
  logic [1:0] finish_set;
  logic [3:0] remain;
  logic [1:0] round_left;

  modport master (
    output key_inc, key_confirm, key_start, key_stop,
    input  work_mode, start, finish, stop, finish_set, remain, round_left
  );

  modport slave (
    input  key_inc, key_confirm, key_start, key_stop,
    output work_mode, start, finish, stop, finish_set, remain, round_left
  );
endinterface

// File: rtl/work_controller.sv
// Washer front-panel sequencer: settings entry, run/pause/stop control and
// the per-second countdown over dur x reps rounds.
module work_controller #(
  parameter int TICK_CYCLES = 100_000_000
) (
  input logic             sys_clk,
  input logic             sys_rst,
  work_controller_if.slave bus
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  localparam logic [2:0] S_SET0    = 3'd0;
  localparam logic [2:0] S_SET1    = 3'd1;
  localparam logic [2:0] S_READY   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_STOPPED = 3'd6;

  logic [2:0]       state, state_n;
  logic [3:0]       dur, dur_n;
  logic [1:0]       reps, reps_n;
  logic [3:0]       remain, remain_n;
  logic [1:0]       round_left, round_left_n;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_n;

  logic stop_ok, start_ok, confirm_ok, inc_ok;
  logic do_stop, do_start, do_confirm, do_inc;
  logic tick, final_tick;

  // Key arbitration, countdown and next-state selection.
  always_comb begin
    state_n      = state;
    dur_n        = dur;
    reps_n       = reps;
    remain_n     = remain;
    round_left_n = round_left;
    tick_cnt_n   = '0;

    stop_ok    = (state == S_READY) || (state == S_RUN) || (state == S_PAUSE);
    start_ok   = stop_ok;
    confirm_ok = (state == S_SET0) || (state == S_SET1) ||
                 (state == S_DONE) || (state == S_STOPPED);
    inc_ok     = (state == S_SET0) || (state == S_SET1);

    // Only the highest-priority key that means something here acts.
    do_stop    = bus.key_stop    && stop_ok;
    do_start   = bus.key_start   && start_ok   && !do_stop;
    do_confirm = bus.key_confirm && confirm_ok && !do_stop && !do_start;
    do_inc     = bus.key_inc     && inc_ok     && !do_stop && !do_start && !do_confirm;

    tick       = (state == S_RUN) && (tick_cnt == CNT_LAST);
    final_tick = tick && (remain == 4'd1) && (round_left == 2'd1);

    // The tick is applied before any key so a coinciding pause sees its result.
    if (state == S_RUN) begin
      tick_cnt_n = tick ? '0 : tick_cnt + CNT_W'(1);
      if (tick) begin
        if (remain > 4'd1) begin
          remain_n = remain - 4'd1;
        end else if (round_left > 2'd1) begin
          round_left_n = round_left - 2'd1;
          remain_n     = dur;
        end else begin
          remain_n     = 4'd0;
          round_left_n = 2'd0;
          state_n      = S_DONE;
        end
      end
    end else if (state == S_PAUSE) begin
      tick_cnt_n = tick_cnt;
    end

    if (do_stop) begin
      state_n      = S_STOPPED;
      remain_n     = 4'd0;
      round_left_n = 2'd0;
    end else if (do_start) begin
      unique case (state)
        S_READY: begin
          state_n      = S_RUN;
          remain_n     = dur;
          round_left_n = reps;
          tick_cnt_n   = '0;
        end
        S_RUN:   if (!final_tick) state_n = S_PAUSE;
        S_PAUSE: state_n = S_RUN;
        default: ;
      endcase
    end else if (do_confirm) begin
      unique case (state)
        S_SET0:    state_n = S_SET1;
        S_SET1:    state_n = S_READY;
        S_DONE:    state_n = S_SET0;
        S_STOPPED: state_n = S_SET0;
        default:   ;
      endcase
    end else if (do_inc) begin
      if (state == S_SET0) begin
        dur_n = (dur == 4'd15) ? 4'd1 : dur + 4'd1;
      end else begin
        reps_n = (reps == 2'd3) ? 2'd1 : reps + 2'd1;
      end
    end

    // The second counter only carries meaning while a job is live.
    if ((state_n != S_RUN) && (state_n != S_PAUSE)) begin
      tick_cnt_n = '0;
    end
  end

  // State, settings and countdown registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_SET0;
      dur        <= 4'd5;
      reps       <= 2'd1;
      remain     <= 4'd0;
      round_left <= 2'd0;
      tick_cnt   <= '0;
    end else begin
      state      <= state_n;
      dur        <= dur_n;
      reps       <= reps_n;
      remain     <= remain_n;
      round_left <= round_left_n;
      tick_cnt   <= tick_cnt_n;
    end
  end

  // Indicator levels decoded straight from the state register.
  always_comb begin
    bus.work_mode  = (state == S_RUN) || (state == S_PAUSE);
    bus.start      = (state == S_RUN);
    bus.finish     = (state == S_DONE);
    bus.stop       = (state == S_STOPPED);
    bus.finish_set = 2'd0;
    if (state == S_SET1) begin
      bus.finish_set = 2'd1;
    end else if ((state == S_READY) || (state == S_RUN) ||
                 (state == S_PAUSE) || (state == S_DONE)) begin
      bus.finish_set = 2'd2;
    end
    bus.remain     = remain;
    bus.round_left = round_left;
  end

endmodule

// File: tb/tb_work_controller.sv
// Directed bench for work_controller with a 4-cycle second.
module tb_work_controller;

  logic sys_clk;
  logic sys_rst;
  int   total;
  int   bad;

  work_controller_if bus ();

  work_controller #(.TICK_CYCLES(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // {work_mode, start, finish, stop, finish_set}
  function automatic logic [5:0] flags();
    return {bus.work_mode, bus.start, bus.finish, bus.stop, bus.finish_set};
  endfunction

  // Advance n edges and settle 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #3;
    sys_rst = 1'b0;
    cyc(1);
  endtask

  task automatic press(input logic inc, input logic conf, input logic st, input logic sp);
    bus.key_inc = inc; bus.key_confirm = conf; bus.key_start = st; bus.key_stop = sp;
    cyc(1);
    bus.key_inc = 1'b0; bus.key_confirm = 1'b0; bus.key_start = 1'b0; bus.key_stop = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    cyc(2);
    total++; if (flags() !== 6'b000000) begin bad++; $display("FAIL reset_flags got=%b want=000000", flags()); end
    total++; if (bus.remain !== 4'd0) begin bad++; $display("FAIL reset_remain got=%0d want=0", bus.remain); end
    total++; if (bus.round_left !== 2'd0) begin bad++; $display("FAIL reset_round got=%0d want=0", bus.round_left); end
    total++; if (dut.dur !== 4'd5) begin bad++; $display("FAIL reset_dur got=%0d want=5", dut.dur); end
    total++; if (dut.reps !== 2'd1) begin bad++; $display("FAIL reset_reps got=%0d want=1", dut.reps); end
    sys_rst = 1'b0;
    cyc(1);
    incs(3);
    total++; if (dut.dur !== 4'd8) begin bad++; $display("FAIL inc3_dur got=%0d want=8", dut.dur); end
    total++; if (flags() !== 6'b000000) begin bad++; $display("FAIL inc3_flags got=%b want=000000", flags()); end
  endtask

  task automatic test_settings();
    do_reset();
    incs(11);
    total++; if (dut.dur !== 4'd1) begin bad++; $display("FAIL dur_wrap got=%0d want=1", dut.dur); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (flags() !== 6'b000001) begin bad++; $display("FAIL set1_flags got=%b want=000001", flags()); end
    incs(3);
    total++; if (dut.reps !== 2'd1) begin bad++; $display("FAIL reps_wrap got=%0d want=1", dut.reps); end
    total++; if (dut.dur !== 4'd1) begin bad++; $display("FAIL dur_kept_set1 got=%0d want=1", dut.dur); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (flags() !== 6'b000010) begin bad++; $display("FAIL ready_flags got=%b want=000010", flags()); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (flags() !== 6'b000100) begin bad++; $display("FAIL ready_stop got=%b want=000100", flags()); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (flags() !== 6'b000000) begin bad++; $display("FAIL set0_stop_ignored got=%b want=000000", flags()); end
    total++; if (dut.dur !== 4'd1) begin bad++; $display("FAIL dur_after_stop got=%0d want=1", dut.dur); end
  endtask

  task automatic test_countdown();
    do_reset();
    incs(12);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    incs(1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (flags() !== 6'b110010) begin bad++; $display("FAIL run_flags got=%b want=110010", flags()); end
    total++; if (bus.remain !== 4'd2) begin bad++; $display("FAIL run_remain0 got=%0d want=2", bus.remain); end
    total++; if (bus.round_left !== 2'd2) begin bad++; $display("FAIL run_round0 got=%0d want=2", bus.round_left); end
    cyc(3);
    total++; if (bus.remain !== 4'd2) begin bad++; $display("FAIL run_e3_remain got=%0d want=2", bus.remain); end
    cyc(1);
    total++; if (bus.remain !== 4'd1) begin bad++; $display("FAIL run_e4_remain got=%0d want=1", bus.remain); end
    cyc(4);
    total++; if (bus.remain !== 4'd2) begin bad++; $display("FAIL run_e8_remain got=%0d want=2", bus.remain); end
    total++; if (bus.round_left !== 2'd1) begin bad++; $display("FAIL run_e8_round got=%0d want=1", bus.round_left); end
    cyc(7);
    total++; if (flags() !== 6'b110010) begin bad++; $display("FAIL run_e15_flags got=%b want=110010", flags()); end
    total++; if (bus.remain !== 4'd1) begin bad++; $display("FAIL run_e15_remain got=%0d want=1", bus.remain); end
    cyc(1);
    total++; if (flags() !== 6'b001010) begin bad++; $display("FAIL done_flags got=%b want=001010", flags()); end
    total++; if (bus.remain !== 4'd0) begin bad++; $display("FAIL done_remain got=%0d want=0", bus.remain); end
    total++; if (bus.round_left !== 2'd0) begin bad++; $display("FAIL done_round got=%0d want=0", bus.round_left); end
    cyc(5);
    total++; if (bus.finish !== 1'b1) begin bad++; $display("FAIL done_level got=%b want=1", bus.finish); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (flags() !== 6'b000000) begin bad++; $display("FAIL done_ack got=%b want=000000", flags()); end
    total++; if (dut.dur !== 4'd2) begin bad++; $display("FAIL done_dur_kept got=%0d want=2", dut.dur); end
  endtask

  task automatic test_pause();
    do_reset();
    incs(13);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(5);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (flags() !== 6'b100010) begin bad++; $display("FAIL pause_flags got=%b want=100010", flags()); end
    total++; if (bus.remain !== 4'd2) begin bad++; $display("FAIL pause_remain got=%0d want=2", bus.remain); end
    cyc(20);
    total++; if (bus.remain !== 4'd2) begin bad++; $display("FAIL pause_hold got=%0d want=2", bus.remain); end
    total++; if (flags() !== 6'b100010) begin bad++; $display("FAIL pause_hold_flags got=%b want=100010", flags()); end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (flags() !== 6'b110010) begin bad++; $display("FAIL resume_flags got=%b want=110010", flags()); end
    cyc(1);
    total++; if (bus.remain !== 4'd2) begin bad++; $display("FAIL resume_r1 got=%0d want=2", bus.remain); end
    cyc(1);
    total++; if (bus.remain !== 4'd1) begin bad++; $display("FAIL resume_r2 got=%0d want=1", bus.remain); end
    cyc(3);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (flags() !== 6'b001010) begin bad++; $display("FAIL pause_on_final got=%b want=001010", flags()); end
    total++; if (bus.remain !== 4'd0) begin bad++; $display("FAIL pause_on_final_remain got=%0d want=0", bus.remain); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stop();
    do_reset();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(2);
    press(1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (flags() !== 6'b000100) begin bad++; $display("FAIL stop_start_flags got=%b want=000100", flags()); end
    total++; if (bus.remain !== 4'd0) begin bad++; $display("FAIL stop_remain got=%0d want=0", bus.remain); end
    total++; if (bus.round_left !== 2'd0) begin bad++; $display("FAIL stop_round got=%0d want=0", bus.round_left); end
    cyc(3);
    total++; if (bus.stop !== 1'b1) begin bad++; $display("FAIL stop_level got=%b want=1", bus.stop); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (flags() !== 6'b000000) begin bad++; $display("FAIL stop_ack got=%b want=000000", flags()); end
    total++; if (dut.dur !== 4'd5) begin bad++; $display("FAIL stop_dur_kept got=%0d want=5", dut.dur); end
    // Stop landing on the final tick of a one-second job.
    incs(11);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(3);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (flags() !== 6'b000100) begin bad++; $display("FAIL stop_final_tick got=%b want=000100", flags()); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    do_reset();
    incs(2);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    incs(1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(6);
    total++; if (flags() !== 6'b110010) begin bad++; $display("FAIL midrun_pre got=%b want=110010", flags()); end
    #2;
    sys_rst = 1'b1;
    #1;
    total++; if (flags() !== 6'b000000) begin bad++; $display("FAIL midrun_rst_flags got=%b want=000000", flags()); end
    total++; if (bus.remain !== 4'd0) begin bad++; $display("FAIL midrun_rst_remain got=%0d want=0", bus.remain); end
    total++; if (bus.round_left !== 2'd0) begin bad++; $display("FAIL midrun_rst_round got=%0d want=0", bus.round_left); end
    total++; if (dut.dur !== 4'd5) begin bad++; $display("FAIL midrun_rst_dur got=%0d want=5", dut.dur); end
    total++; if (dut.reps !== 2'd1) begin bad++; $display("FAIL midrun_rst_reps got=%0d want=1", dut.reps); end
    cyc(1);
    sys_rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    sys_rst         = 1'b1;
    bus.key_inc     = 1'b0;
    bus.key_confirm = 1'b0;
    bus.key_start   = 1'b0;
    bus.key_stop    = 1'b0;
    test_reset();
    test_settings();
    test_countdown();
    test_pause();
    test_stop();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
